// File: rtl/counter_pkg.sv
// counter_pkg
// Shared types and helpers for the counter sequencer/arbiter slice.
//   ctrl_state_e  : sequencer FSM states (IDLE waits for a request, ISSUE
//                   drives the one-cycle ack/nack and inc/dec pulses)
//   CNT_W_DEFAULT : default counter width
//   N_REQ_DEFAULT : default number of requesting clients
//   sat_refuse()  : saturation verdict for one requested operation
package counter_pkg;

  typedef enum logic {
    CTRL_IDLE,
    CTRL_ISSUE
  } ctrl_state_e;

  localparam int CNT_W_DEFAULT = 8;
  localparam int N_REQ_DEFAULT = 4;

  // An operation is refused only when saturation is enabled and it would
  // wrap the counter: inc at all-ones or dec at zero.
  function automatic logic sat_refuse(input logic sat_en,
                                      input logic dir_inc,
                                      input logic at_max,
                                      input logic at_zero);
    return sat_en && ((dir_inc && at_max) || (!dir_inc && at_zero));
  endfunction

endpackage

// File: rtl/counter_rr_arb.sv
// counter_rr_arb
// Combinational round-robin pick among the pending requests.
//   req     : per-client request vector
//   ptr     : index where the search starts (ascending, wrapping)
//   win_idx : index of the first requesting client found from ptr
//   valid   : at least one request is pending
module counter_rr_arb
  import counter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] win_idx,
  output logic             valid
);

  // Walk the clients starting at ptr; the first hit wins, later hits are
  // ignored because valid is already set.
  always_comb begin : pick
    int cand;
    cand    = 0;
    win_idx = '0;
    valid   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!valid && req[cand[IDX_W-1:0]]) begin
        valid   = 1'b1;
        win_idx = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl
// Sequencer and round-robin arbiter in front of a shared inc/dec counter.
// One client is granted per two cycles; the granted operation is either
// issued to the counter (ack + inc/dec pulse) or refused when it would
// wrap the counter and SAT is set (nack).
//   clk, rst : clock and synchronous active-high reset
//   req, dir : per-client request and direction (1 = inc, 0 = dec)
//   ack,nack : one-hot one-cycle grant results
//   inc, dec : one-cycle pulses to the counter
//   cnt      : current counter value (feedback)
//   busy     : high during the cycle the result is issued
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter bit SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] dir,
  output logic [N_REQ-1:0] ack,
  output logic [N_REQ-1:0] nack,
  output logic             inc,
  output logic             dec,
  input  logic [CNT_W-1:0] cnt,
  output logic             busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ctrl_state_e      state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] win_q, win_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [N_REQ-1:0] nack_q, nack_d;
  logic             inc_q, inc_d;
  logic             dec_q, dec_d;
  logic             busy_q, busy_d;

  logic [IDX_W-1:0] arb_win;
  logic             arb_valid;
  logic [N_REQ-1:0] grant_oh;
  logic             refuse;

  counter_rr_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .win_idx (arb_win),
    .valid   (arb_valid)
  );

  // The grant decision, the winner's direction and the saturation verdict
  // are all resolved in IDLE against the live cnt and captured directly in
  // the output flops, so ISSUE just presents them. Only the winner index is
  // kept separately because the pointer advances from it when ISSUE ends.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    ack_d    = '0;
    nack_d   = '0;
    inc_d    = 1'b0;
    dec_d    = 1'b0;
    busy_d   = 1'b0;
    grant_oh = N_REQ'(1) << arb_win;
    refuse   = sat_refuse(SAT, dir[arb_win], cnt == CNT_MAX, cnt == '0);

    case (state_q)
      CTRL_IDLE: begin
        if (arb_valid) begin
          win_d   = arb_win;
          state_d = CTRL_ISSUE;
          busy_d  = 1'b1;
          if (refuse) begin
            nack_d = grant_oh;
          end else begin
            ack_d = grant_oh;
            inc_d = dir[arb_win];
            dec_d = !dir[arb_win];
          end
        end
      end
      CTRL_ISSUE: begin
        // req is not looked at here; the next search starts after the winner
        ptr_d   = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
        state_d = CTRL_IDLE;
      end
      default: state_d = CTRL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CTRL_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      ack_q   <= '0;
      nack_q  <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      ack_q   <= ack_d;
      nack_q  <= nack_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      busy_q  <= busy_d;
    end
  end

  assign ack  = ack_q;
  assign nack = nack_q;
  assign inc  = inc_q;
  assign dec  = dec_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl
// Bench for counter_ctrl: one saturating instance and one wrapping instance,
// each driving a small behavioural counter. Expected grant results are queued
// when a request is driven and compared when the DUT pulses ack/nack/inc/dec.
module tb_counter_ctrl;

  typedef struct packed {
    logic [3:0] ack;
    logic [3:0] nack;
    logic       inc;
    logic       dec;
    logic       busy;
  } obs_t;

  logic       clk;
  logic       rst;
  logic [3:0] req0, dir0, ack0, nack0;
  logic       inc0, dec0, busy0;
  logic [7:0] cnt0, load_val0;
  logic       load0;
  logic [3:0] req_w, dir_w, ack_w, nack_w;
  logic       inc_w, dec_w, busy_w;
  logic [7:0] cnt_w, load_val_w;
  logic       load_w;

  obs_t obs0, obs_wv, exp0, exp_wv;
  obs_t q0[$];
  obs_t q_w[$];

  int checks;
  int errors;

  assign obs0   = {ack0, nack0, inc0, dec0, busy0};
  assign obs_wv = {ack_w, nack_w, inc_w, dec_w, busy_w};

  counter_ctrl #(.N_REQ(4), .CNT_W(8), .SAT(1'b1)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req0),
    .dir  (dir0),
    .ack  (ack0),
    .nack (nack0),
    .inc  (inc0),
    .dec  (dec0),
    .cnt  (cnt0),
    .busy (busy0)
  );

  counter_ctrl #(.N_REQ(4), .CNT_W(8), .SAT(1'b0)) dut_wrap (
    .clk  (clk),
    .rst  (rst),
    .req  (req_w),
    .dir  (dir_w),
    .ack  (ack_w),
    .nack (nack_w),
    .inc  (inc_w),
    .dec  (dec_w),
    .cnt  (cnt_w),
    .busy (busy_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural counters fed by the inc/dec pulses, with a bench-side load.
  always @(posedge clk) begin
    if (load0) cnt0 <= load_val0;
    else if (inc0) cnt0 <= cnt0 + 8'd1;
    else if (dec0) cnt0 <= cnt0 - 8'd1;
  end

  always @(posedge clk) begin
    if (load_w) cnt_w <= load_val_w;
    else if (inc_w) cnt_w <= cnt_w + 8'd1;
    else if (dec_w) cnt_w <= cnt_w - 8'd1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic obs_t mkObs(input logic [3:0] a, input logic [3:0] n,
                                 input logic i, input logic d);
    obs_t o;
    o = {a, n, i, d, 1'b1};
    return o;
  endfunction

  // Scoreboard monitors: any activity must match the oldest queued result.
  always @(negedge clk) begin
    if (|{ack0, nack0, inc0, dec0}) begin
      checkOutput("excl0", 32'(inc0 & dec0), 32'd0);
      checkOutput("onehot0", $countones({ack0, nack0}), 32'd1);
      checkOutput("busy_pulse0", 32'(busy0), 32'd1);
      if (q0.size() == 0) checkOutput("sb_unexpected0", 32'(obs0), 32'd0);
      else begin
        exp0 = q0.pop_front();
        checkOutput("sb0", 32'(obs0), 32'(exp0));
      end
    end else if (busy0) begin
      checkOutput("busy_idle0", 32'(busy0), 32'd0);
    end
  end

  always @(negedge clk) begin
    if (|{ack_w, nack_w, inc_w, dec_w}) begin
      checkOutput("excl_w", 32'(inc_w & dec_w), 32'd0);
      checkOutput("onehot_w", $countones({ack_w, nack_w}), 32'd1);
      checkOutput("busy_pulse_w", 32'(busy_w), 32'd1);
      if (q_w.size() == 0) checkOutput("sb_unexpected_w", 32'(obs_wv), 32'd0);
      else begin
        exp_wv = q_w.pop_front();
        checkOutput("sb_w", 32'(obs_wv), 32'(exp_wv));
      end
    end else if (busy_w) begin
      checkOutput("busy_idle_w", 32'(busy_w), 32'd0);
    end
  end

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic loadCnt(input bit wrap, input logic [7:0] v);
    @(negedge clk);
    if (wrap) begin load_w = 1'b1; load_val_w = v; end
    else begin load0 = 1'b1; load_val0 = v; end
    @(negedge clk);
    load0  = 1'b0;
    load_w = 1'b0;
  endtask

  // Single request from an idle DUT: result one cycle after the sampling
  // edge, counter value and busy checked in the following cycle.
  task automatic applyStimulus(input bit wrap, input logic [1:0] client,
                               input logic d, input obs_t expo,
                               input logic [7:0] cnt_exp);
    int lat;
    bit seen;
    if (wrap) begin
      q_w.push_back(expo);
      dir_w[client] = d;
      req_w[client] = 1'b1;
    end else begin
      q0.push_back(expo);
      dir0[client] = d;
      req0[client] = 1'b1;
    end
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 10) begin
      @(negedge clk);
      lat++;
      if (wrap) seen = ack_w[client] | nack_w[client];
      else      seen = ack0[client] | nack0[client];
    end
    checkOutput("grant_latency", lat, 32'd1);
    req0  = '0;
    req_w = '0;
    @(negedge clk);
    checkOutput("cnt_after", wrap ? cnt_w : cnt0, 32'(cnt_exp));
    checkOutput("busy_after", 32'(wrap ? busy_w : busy0), 32'd0);
  endtask

  initial begin
    int cyc, seen, last;
    logic [1:0] c;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    req0 = '0; dir0 = '0; req_w = '0; dir_w = '0;
    load0 = 1'b0; load_w = 1'b0; load_val0 = '0; load_val_w = '0;

    // Reset state
    doReset();
    checkOutput("reset_outputs0", 32'(obs0), 32'd0);
    checkOutput("reset_outputs_w", 32'(obs_wv), 32'd0);

    // Single client 0 increment
    loadCnt(1'b0, 8'h10);
    applyStimulus(1'b0, 2'd0, 1'b1, mkObs(4'b0001, 4'b0000, 1'b1, 1'b0), 8'h11);

    // All four clients continuously, grant order 0,1,2,3,0 every 2 cycles
    doReset();
    loadCnt(1'b0, 8'h80);
    dir0 = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      c = 2'(i % 4);
      q0.push_back(mkObs(4'(1) << c, 4'b0000, dir0[c], !dir0[c]));
    end
    req0 = 4'b1111;
    cyc = 0; seen = 0; last = 0;
    while (seen < 5 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (|(ack0 | nack0)) begin
        seen++;
        if (seen > 1) checkOutput("cont_spacing", cyc - last, 32'd2);
        last = cyc;
        if (seen == 5) req0 = '0;
      end
    end
    checkOutput("cont_grants", seen, 32'd5);
    @(negedge clk);
    checkOutput("cont_cnt", 32'(cnt0), 32'h81);

    // Saturation at all-ones, then the opposite direction is allowed
    loadCnt(1'b0, 8'hFF);
    applyStimulus(1'b0, 2'd2, 1'b1, mkObs(4'b0000, 4'b0100, 1'b0, 1'b0), 8'hFF);
    applyStimulus(1'b0, 2'd2, 1'b0, mkObs(4'b0100, 4'b0000, 1'b0, 1'b1), 8'hFE);

    // Saturation at zero vs wrapping instance
    loadCnt(1'b0, 8'h00);
    applyStimulus(1'b0, 2'd1, 1'b0, mkObs(4'b0000, 4'b0010, 1'b0, 1'b0), 8'h00);
    loadCnt(1'b1, 8'h00);
    applyStimulus(1'b1, 2'd1, 1'b0, mkObs(4'b0010, 4'b0000, 1'b0, 1'b1), 8'hFF);
    applyStimulus(1'b1, 2'd3, 1'b1, mkObs(4'b1000, 4'b0000, 1'b1, 1'b0), 8'h00);

    // Reset while in ISSUE, and reset dominating a fresh request
    q0.push_back(mkObs(4'b0010, 4'b0000, 1'b1, 1'b0));
    dir0[1] = 1'b1;
    req0 = 4'b0010;
    @(negedge clk);
    checkOutput("pre_rst_ack", 32'(ack0), 32'h2);
    rst = 1'b1;
    req0 = '0;
    @(negedge clk);
    checkOutput("rst_issue_clear", 32'(obs0), 32'd0);
    dir0[2] = 1'b1;
    req0 = 4'b0100;
    @(negedge clk);
    checkOutput("rst_dominates", 32'(obs0), 32'd0);
    rst = 1'b0;
    dir0[0] = 1'b1;
    dir0[3] = 1'b0;
    q0.push_back(mkObs(4'b0001, 4'b0000, 1'b1, 1'b0));
    q0.push_back(mkObs(4'b1000, 4'b0000, 1'b0, 1'b1));
    req0 = 4'b1001;
    for (int g = 0; g < 2; g++) begin
      cyc = 0;
      while (!(|(ack0 | nack0)) && cyc < 10) begin
        @(negedge clk);
        cyc++;
      end
      if (g == 0) begin
        checkOutput("rr_after_rst_first", 32'(ack0), 32'h1);
        req0[0] = 1'b0;
      end else begin
        checkOutput("rr_after_rst_second", 32'(ack0), 32'h8);
        req0[3] = 1'b0;
      end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);

    checkOutput("sb_drained0", q0.size(), 32'd0);
    checkOutput("sb_drained_w", q_w.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Sequencer and arbiter for the shared 8-bit inc/dec counter. Up to N_REQ clients each request a single increment or decrement through a req/ack handshake. A round-robin arbiter grants one client at a time, and the block drives the counter's inc/dec pins with a one-cycle pulse. With SAT=1 the block refuses operations that would wrap the counter.

## Interface
- N_REQ, default 4: number of requesting clients (2..8).
- CNT_W, default 8: counter width; must match the counter.
- SAT, default 1: 1 = refuse inc at all-ones and dec at zero (nack); 0 = allow wrap.

- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- req  input  N_REQ  per-client request, held until ack or nack.
- dir  input  N_REQ  per-client direction, 1 = inc, 0 = dec; stable while req high.
- ack  output  N_REQ  one-hot one-cycle pulse: operation issued to counter.
- nack  output  N_REQ  one-hot one-cycle pulse: operation refused (saturation).
- inc  output  1  counter increment pulse.
- dec  output  1  counter decrement pulse.
- cnt  input  CNT_W  current counter value (feedback).
- busy  output  1  high while in ISSUE.

## Operation
- Reset values: ack=0, nack=0, inc=0, dec=0, busy=0, state=IDLE, rr pointer=0.
- FSM states:
  - IDLE: if any req, pick winner round-robin, starting search at pointer, ascending index, wrapping. Register winner index, dir[winner] and the saturation verdict. Go to ISSUE. If no req, stay in IDLE.
  - ISSUE: drive ack[w] or nack[w] high for exactly this cycle.
    - If ack: inc=dir_q, dec=!dir_q, both only this cycle.
    - If nack: inc=dec=0.
    - Pointer ← (w+1) mod N_REQ; go to IDLE.
- Saturation verdict (SAT=1 only), evaluated in IDLE from the live cnt:
  - inc with cnt==2^CNT_W−1 → nack.
  - dec with cnt==0 → nack.
  - Otherwise ack.
  - SAT=0: always ack.
- inc and dec are never both high. All outputs are registered.
- ISSUE does not re-sample req. A client dropping req before its ack is a protocol violation; the issued op still completes.
- Clients not granted keep req high. The arbiter never starves: each client waits at most N_REQ−1 grants.

## Timing
- Request seen in IDLE at cycle t → ack/nack and inc/dec at cycle t+1. Counter updates at the edge ending t+1; the new cnt is visible at t+2.
- Back-to-back throughput: one operation per 2 cycles. The IDLE cycle at t+2 sees the updated cnt, so the saturation check is never stale.
- The client must deassert req in the cycle after ack/nack (t+2). A req still high at t+2 is treated as a new request.
- Reset asserted in ISSUE: the next cycle is IDLE with all outputs 0 and pointer 0. A pulse suppressed by reset is lost and the client must re-request.
- Reset dominates all other inputs in the same cycle.

## Structure
- Shared package counter_pkg:
  - typedef enum logic {CTRL_IDLE, CTRL_ISSUE} ctrl_state_e.
  - Localparam helper for CNT_MAX.
- Sub-module counter_rr_arb: combinational round-robin pick.
  - Inputs: req vector and pointer.
  - Outputs: winner index and valid.
  - Pointer register stays in counter_ctrl.
- counter_ctrl instantiates counter_rr_arb once and holds the FSM, winner/dir/verdict registers and output registers.

## Test plan
- Reset, then single client 0 inc with cnt=8'h10 → ack[0] and inc at t+1, dec=0; cnt becomes 8'h11 at t+2; busy high only at t+1.
- All four clients request continuously, cnt mid-range → grant order 0,1,2,3,0, one ack every 2 cycles; inc/dec follows each client's dir.
- SAT=1, cnt=8'hFF, client 2 inc → nack[2], inc=dec=0, cnt stays 8'hFF. Then client 2 dec → ack[2], dec=1, cnt=8'hFE.
- SAT=1, cnt=8'h00, dec → nack. Same with SAT=0 → ack and dec=1; cnt wraps to 8'hFF.
- Reset asserted during ISSUE → inc/dec/ack low that cycle and after; pointer back to 0; next request from client 3 with client 0 also pending → client 0 granted first.
- Concurrent-assertion check over all runs: never inc&&dec, never more than one bit of ack|nack, never ack/nack outside ISSUE.
